// File: rtl/alu_pkg.sv
// Shared ALU control encodings: abstract opcodes, slice operations, compare
// selects and the per-slice control bundle consumed by the ALU array.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SGT  = 4'd7;
  localparam logic [3:0] OP_SLE  = 4'd8;
  localparam logic [3:0] OP_SGE  = 4'd9;
  localparam logic [3:0] OP_SEQ  = 4'd10;
  localparam logic [3:0] OP_SNE  = 4'd11;

  localparam logic [1:0] SLICE_AND = 2'd0;
  localparam logic [1:0] SLICE_OR  = 2'd1;
  localparam logic [1:0] SLICE_SUM = 2'd2;
  localparam logic [1:0] SLICE_CMP = 2'd3;

  localparam logic [2:0] BONUS_LT   = 3'd0;
  localparam logic [2:0] BONUS_GT   = 3'd1;
  localparam logic [2:0] BONUS_LE   = 3'd2;
  localparam logic [2:0] BONUS_GE   = 3'd3;
  localparam logic [2:0] BONUS_EQ   = 3'd4;
  localparam logic [2:0] BONUS_NE   = 3'd5;
  localparam logic [2:0] BONUS_ZERO = 3'd7;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic       cin;
    logic [1:0] operation;
    logic [2:0] bonus_op;
    logic       illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Handshake and payload bundle between the upstream issuer and the ALU issue
// stage; master drives requests and consumes the decoded bundle.
interface alu_issue_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       in_op_i;
  logic [WIDTH-1:0] in_src1_i;
  logic [WIDTH-1:0] in_src2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_src1_o;
  logic [WIDTH-1:0] out_src2_o;
  logic             out_a_invert_o;
  logic             out_b_invert_o;
  logic             out_cin_o;
  logic [1:0]       out_operation_o;
  logic [2:0]       out_bonus_op_o;
  logic             out_illegal_o;

  modport master (
    output in_valid_i, in_op_i, in_src1_i, in_src2_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_src1_o, out_src2_o, out_a_invert_o,
           out_b_invert_o, out_cin_o, out_operation_o, out_bonus_op_o, out_illegal_o
  );

  modport slave (
    input  in_valid_i, in_op_i, in_src1_i, in_src2_i, out_ready_i,
    output in_ready_o, out_valid_o, out_src1_o, out_src2_o, out_a_invert_o,
           out_b_invert_o, out_cin_o, out_operation_o, out_bonus_op_o, out_illegal_o
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode-to-slice-control decoder, shared with the single-cycle
// datapath. Unknown opcodes select a constant-zero compare and flag illegal.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output alu_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_ADD:  ctrl.operation = SLICE_SUM;
      OP_SUB:  begin ctrl.b_invert = 1'b1; ctrl.cin = 1'b1; ctrl.operation = SLICE_SUM; end
      OP_AND:  ctrl.operation = SLICE_AND;
      OP_OR:   ctrl.operation = SLICE_OR;
      // De Morgan: ~a & ~b is NOR, ~a | ~b is NAND
      OP_NOR:  begin ctrl.a_invert = 1'b1; ctrl.b_invert = 1'b1; ctrl.operation = SLICE_AND; end
      OP_NAND: begin ctrl.a_invert = 1'b1; ctrl.b_invert = 1'b1; ctrl.operation = SLICE_OR; end
      OP_SLT, OP_SGT, OP_SLE, OP_SGE, OP_SEQ, OP_SNE: begin
        ctrl.b_invert  = 1'b1;
        ctrl.cin       = 1'b1;
        ctrl.operation = SLICE_CMP;
        case (op)
          OP_SLT:  ctrl.bonus_op = BONUS_LT;
          OP_SGT:  ctrl.bonus_op = BONUS_GT;
          OP_SLE:  ctrl.bonus_op = BONUS_LE;
          OP_SGE:  ctrl.bonus_op = BONUS_GE;
          OP_SEQ:  ctrl.bonus_op = BONUS_EQ;
          default: ctrl.bonus_op = BONUS_NE;
        endcase
      end
      default: begin
        ctrl.operation = SLICE_CMP;
        ctrl.bonus_op  = BONUS_ZERO;
        ctrl.illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decodes the opcode and holds it in a main/skid pair
// so in_ready_o is purely registered. Define ALU_ISSUE_PERF_EN for perf counters.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_issue_stage_if.slave  bus
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       issue_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;
  alu_ctrl_t        in_ctrl;
  alu_ctrl_t        main_ctrl_reg;
  alu_ctrl_t        skid_ctrl_reg;
  logic [WIDTH-1:0] main_src1_reg;
  logic [WIDTH-1:0] main_src2_reg;
  logic [WIDTH-1:0] skid_src1_reg;
  logic [WIDTH-1:0] skid_src2_reg;
  logic             accept;
  logic             emit;

  alu_ctrl_decode u_decode (
    .op   (bus.in_op_i),
    .ctrl (in_ctrl)
  );

  assign accept = bus.in_valid_i && in_ready_reg;
  assign emit   = out_valid_reg && bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= EMPTY;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      main_ctrl_reg <= '0;
      skid_ctrl_reg <= '0;
      main_src1_reg <= '0;
      main_src2_reg <= '0;
      skid_src1_reg <= '0;
      skid_src2_reg <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_ctrl_reg <= in_ctrl;
            main_src1_reg <= bus.in_src1_i;
            main_src2_reg <= bus.in_src2_i;
            out_valid_reg <= 1'b1;
            state_reg     <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_ctrl_reg <= in_ctrl;
            main_src1_reg <= bus.in_src1_i;
            main_src2_reg <= bus.in_src2_i;
          end else if (accept) begin
            // Downstream stalled: park the new op so upstream never sees a comb ready.
            skid_ctrl_reg <= in_ctrl;
            skid_src1_reg <= bus.in_src1_i;
            skid_src2_reg <= bus.in_src2_i;
            in_ready_reg  <= 1'b0;
            state_reg     <= FULL;
          end else if (emit) begin
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            main_ctrl_reg <= skid_ctrl_reg;
            main_src1_reg <= skid_src1_reg;
            main_src2_reg <= skid_src2_reg;
            in_ready_reg  <= 1'b1;
            state_reg     <= ONE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready_o      = in_ready_reg;
  assign bus.out_valid_o     = out_valid_reg;
  assign bus.out_src1_o      = main_src1_reg;
  assign bus.out_src2_o      = main_src2_reg;
  assign bus.out_a_invert_o  = main_ctrl_reg.a_invert;
  assign bus.out_b_invert_o  = main_ctrl_reg.b_invert;
  assign bus.out_cin_o       = main_ctrl_reg.cin;
  assign bus.out_operation_o = main_ctrl_reg.operation;
  assign bus.out_bonus_op_o  = main_ctrl_reg.bonus_op;
  assign bus.out_illegal_o   = main_ctrl_reg.illegal;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (emit)
        issue_cnt_reg <= issue_cnt_reg + 32'd1;
      if (out_valid_reg && !bus.out_ready_i)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign issue_cnt_o = issue_cnt_reg;
  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios plus randomized traffic,
// checked against a queue model of the stage contents and the opcode table.
module tb_alu_issue_stage;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.WIDTH(W)) bus ();

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;
`endif

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .issue_cnt_o (issue_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [8:0]   ctrl;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected {a_invert, b_invert, cin, operation[1:0], bonus_op[2:0], illegal}
  function automatic logic [8:0] ref_ctrl(input logic [3:0] op);
    logic [2:0] sel;
    if (op >= 4'd12) return {3'b000, 2'd3, 3'd7, 1'b1};
    if (op >= 4'd6) begin
      sel = 3'(op - 4'd6);
      return {3'b011, 2'd3, sel, 1'b0};
    end
    case (op)
      4'd0:    return {3'b000, 2'd2, 3'd0, 1'b0};
      4'd1:    return {3'b011, 2'd2, 3'd0, 1'b0};
      4'd2:    return {3'b000, 2'd0, 3'd0, 1'b0};
      4'd3:    return {3'b000, 2'd1, 3'd0, 1'b0};
      4'd4:    return {3'b110, 2'd0, 3'd0, 1'b0};
      default: return {3'b110, 2'd1, 3'd0, 1'b0};
    endcase
  endfunction

  // One clock of stimulus; reports whether the request was taken at the edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic rdy, output logic acc);
    exp_t e;
    bus.in_valid_i = v;
    bus.in_op_i    = op;
    bus.in_src1_i  = a;
    bus.in_src2_i  = b;
    bus.out_ready_i = rdy;
    @(negedge clk);
    acc = v && bus.in_ready_o && !rst;
    @(posedge clk);
    if (rst) sb.delete();
    else if (acc) begin
      e.op = op; e.a = a; e.b = b; e.ctrl = ref_ctrl(op);
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic rdy);
    logic acc;
    for (int n = 0; n < 50; n++) begin
      step(1'b1, op, a, b, rdy, acc);
      if (acc) return;
    end
    checks++; failures++;
    $display("FAIL send_timeout op=%0d not accepted within 50 cycles", op);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, '0, '0, rdy, acc);
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.out_src1_o !== '0 ||
        bus.out_src2_o !== '0 || bus.out_a_invert_o !== 1'b0 || bus.out_b_invert_o !== 1'b0 ||
        bus.out_cin_o !== 1'b0 || bus.out_operation_o !== 2'd0 || bus.out_bonus_op_o !== 3'd0 ||
        bus.out_illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL %s got valid=%b ready=%b src1=%h src2=%h op=%0d bonus=%0d ill=%b, want all zero with ready=1",
               tag, bus.out_valid_o, bus.in_ready_o, bus.out_src1_o, bus.out_src2_o,
               bus.out_operation_o, bus.out_bonus_op_o, bus.out_illegal_o);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: stage contents must equal the scoreboard queue at every mid-cycle sample.
`ifdef ALU_ISSUE_PERF_EN
  int issue_m = 0;
  int stall_m = 0;
`endif
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [8:0] act;
    if (rst) begin
`ifdef ALU_ISSUE_PERF_EN
      issue_m = 0;
      stall_m = 0;
`endif
    end else begin
      checks++;
      if (bus.out_valid_o !== (sb.size() > 0)) begin
        failures++;
        $display("FAIL out_valid got %b want %b (queued=%0d)", bus.out_valid_o, sb.size() > 0, sb.size());
      end
      checks++;
      if (bus.in_ready_o !== (sb.size() < 2)) begin
        failures++;
        $display("FAIL in_ready got %b want %b (queued=%0d)", bus.in_ready_o, sb.size() < 2, sb.size());
      end
      if (bus.out_valid_o === 1'b1 && sb.size() > 0) begin
        e   = sb[0];
        act = {bus.out_a_invert_o, bus.out_b_invert_o, bus.out_cin_o,
               bus.out_operation_o, bus.out_bonus_op_o, bus.out_illegal_o};
        checks++;
        if (bus.out_src1_o !== e.a || bus.out_src2_o !== e.b || act !== e.ctrl) begin
          failures++;
          $display("FAIL payload op=%0d got src1=%h src2=%h ctrl=%b want src1=%h src2=%h ctrl=%b",
                   e.op, bus.out_src1_o, bus.out_src2_o, act, e.a, e.b, e.ctrl);
        end
        if (bus.out_ready_i) begin
          $display("emit op=%0d src1=%h src2=%h ctrl=%b", e.op, e.a, e.b, e.ctrl);
          void'(sb.pop_front());
        end
      end
`ifdef ALU_ISSUE_PERF_EN
      checks++;
      if (issue_cnt !== 32'(issue_m) || stall_cnt !== 32'(stall_m)) begin
        failures++;
        $display("FAIL perf got issue=%0d stall=%0d want issue=%0d stall=%0d",
                 issue_cnt, stall_cnt, issue_m, stall_m);
      end
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i) issue_m++;
      if (bus.out_valid_o === 1'b1 && !bus.out_ready_i) stall_m++;
`endif
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic         acc;
    logic         v;
    logic         rdy;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.in_valid_i  = 1'b0;
    bus.in_op_i     = '0;
    bus.in_src1_i   = '0;
    bus.in_src2_i   = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset_state");

    // Single SUB with one-cycle latency
    send(4'd1, 32'd5, 32'd3, 1'b1);
    idle(3, 1'b1);

    // Back-to-back AND, NOR, SGE, SNE
    send(4'd2, $urandom, $urandom, 1'b1);
    send(4'd4, $urandom, $urandom, 1'b1);
    send(4'd9, $urandom, $urandom, 1'b1);
    send(4'd11, $urandom, $urandom, 1'b1);
    idle(3, 1'b1);

    // Fill under back-pressure; SLT must wait
    send(4'd0, 32'h1111_0000, 32'h0000_2222, 1'b0);
    send(4'd3, 32'h3333_0000, 32'h0000_4444, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'd6, 32'h5555_0000, 32'h0000_6666, 1'b0, acc);
      checks++;
      if (acc) begin
        failures++;
        $display("FAIL full_stall got accept=1 want accept=0 at stall cycle %0d", k);
      end
    end
    send(4'd6, 32'h5555_0000, 32'h0000_6666, 1'b1);
    idle(4, 1'b1);

    // Illegal opcode flows through
    send(4'd13, $urandom, $urandom, 1'b1);
    send(4'd0, $urandom, $urandom, 1'b1);
    idle(3, 1'b1);

    // Reset while FULL, then a lone SEQ
    send(4'd0, $urandom, $urandom, 1'b0);
    send(4'd3, $urandom, $urandom, 1'b0);
    rst = 1'b1;
    step(1'b0, 4'd0, '0, '0, 1'b0, acc);
    rst = 1'b0;
    check_zero("reset_when_full");
    send(4'd10, 32'hdead_beef, 32'hdead_beef, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic; the pending request is held until taken
    for (int i = 0; i < 300; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      acc = 1'b0;
      for (int n = 0; n < 60 && !acc; n++) begin
        v   = ($urandom_range(0, 9) < 7);
        rdy = ($urandom_range(0, 9) < 6);
        step(v, op, a, b, rdy, acc);
      end
      if (!acc) begin
        checks++; failures++;
        $display("FAIL random_accept item %0d op=%0d never accepted", i, op);
      end
    end

    for (int n = 0; n < 20 && sb.size() > 0; n++) idle(1, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d ops still pending want 0", sb.size());
    end
    idle(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue stage directly upstream of the 32-slice ALU array.
- Accepts an abstract ALU opcode plus two operands over a valid/ready handshake.
- Decodes the opcode into the per-slice control bundle (A_invert, B_invert, cin, operation, bonus_op) and presents it with the operands one cycle later.
- A 2-entry skid buffer decouples upstream from ALU/EX back-pressure without a combinational ready path.

Parameters:
- WIDTH, 32, operand width in bits; equals the number of ALU slices.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- in_valid_i  input  1  upstream request valid.
- in_ready_o  output  1  stage can accept; registered, equals !skid_full.
- in_op_i  input  4  abstract ALU opcode.
- in_src1_i  input  WIDTH  operand A.
- in_src2_i  input  WIDTH  operand B.
- out_valid_o  output  1  decoded bundle valid.
- out_ready_i  input  1  ALU/EX consumes the bundle.
- out_src1_o  output  WIDTH  operand A to slices.
- out_src2_o  output  WIDTH  operand B to slices.
- out_a_invert_o  output  1  A_invert to all slices.
- out_b_invert_o  output  1  B_invert to all slices.
- out_cin_o  output  1  carry-in of slice 0.
- out_operation_o  output  2  slice operation: 0 AND, 1 OR, 2 SUM, 3 compare.
- out_bonus_op_o  output  3  compare select: 0 LT, 1 GT, 2 LE, 3 GE, 4 EQ, 5 NE, 7 zero.
- out_illegal_o  output  1  opcode was not in the decode table.

Behaviour:
- Decode table. Opcode maps to {ainv, binv, cin, operation, bonus_op}; unlisted fields are 0.
  - 0 ADD: {0,0,0,2,0}
  - 1 SUB: {0,1,1,2,0}
  - 2 AND: {0,0,0,0,0}
  - 3 OR: {0,0,0,1,0}
  - 4 NOR: {1,1,0,0,0}
  - 5 NAND: {1,1,0,1,0}
  - 6 SLT: {0,1,1,3,0}
  - 7 SGT: {0,1,1,3,1}
  - 8 SLE: {0,1,1,3,2}
  - 9 SGE: {0,1,1,3,3}
  - 10 SEQ: {0,1,1,3,4}
  - 11 SNE: {0,1,1,3,5}
  - 12–15: {0,0,0,3,7} with illegal=1. Illegal ops still flow and produce a zero result.
- Decode is combinational on the input side. The registered result is stored in the main output register.
- Transfer rules:
  - Accept: in_valid_i && in_ready_o.
  - Emit: out_valid_o && out_ready_i.
- Main register behaviour:
  - Loads on accept when it is empty, or when it is emitting in the same cycle.
  - Otherwise the accepted entry goes to the skid register and skid_full sets.
- Skid register behaviour:
  - On emit while skid_full, skid moves to main and skid_full clears.
  - An accept in that same cycle is impossible, because in_ready_o = 0.
- States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY→ONE on accept.
  - ONE→EMPTY on emit without accept.
  - ONE→ONE on emit with accept, or on neither.
  - ONE→FULL on accept without emit.
  - FULL→ONE on emit.
- Latency: 1 cycle from accept to out_valid_o when EMPTY.
- Throughput: 1 op/cycle while out_ready_i = 1.
- Ordering: strictly FIFO. No op is dropped or duplicated.
- in_valid_i without in_ready_o: no state change. Upstream must hold its data.
- Output stability: out_* hold stable while out_valid_o && !out_ready_i.
- Reset (including mid-operation): both entries are discarded, state becomes EMPTY.
  - out_valid_o = 0, in_ready_o = 1 in the cycle after reset.
  - All out_* data and control outputs = 0.

Optional Feature:
- ALU_ISSUE_PERF_EN: adds two ports.
  - issue_cnt_o[31:0] counts emits.
  - stall_cnt_o[31:0] counts cycles with out_valid_o && !out_ready_i.
  - Both are cleared by rst_i and wrap modulo 2^32.
- Without the macro, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_ADD..OP_SNE.
  - Slice operation constants AND/OR/SUM/CMP.
  - bonus_op constants LT/GT/LE/GE/EQ/NE/ZERO.
  - Packed struct alu_ctrl_t {a_invert, b_invert, cin, operation[1:0], bonus_op[2:0], illegal}.
- Sub-module alu_ctrl_decode: purely combinational, maps opcode to alu_ctrl_t. It is reused by the single-cycle datapath.

Test Plan:
- Reset then single SUB, src1=5, src2=3, out_ready_i=1 → next cycle out_valid_o=1, b_invert=1, cin=1, operation=2, bonus_op=0, srcs 5/3; following cycle out_valid_o=0.
- Back-to-back AND, NOR, SGE, SNE with out_ready_i=1 → four consecutive valid cycles. Decodes {0,0,0,0,0}, {1,1,0,0,0}, {0,1,1,3,3}, {0,1,1,3,5}, in order.
- out_ready_i=0 with in_valid_i held high and ops ADD, OR, SLT → ADD and OR accepted. in_ready_o=0 from the cycle after the second accept, and SLT is not taken. Raise out_ready_i → ADD, OR, SLT emerge in order, with no loss or duplication.
- Opcode 13 → illegal=1, operation=3, bonus_op=7. Pipeline continues normally.
- rst_i asserted while FULL → next cycle out_valid_o=0, in_ready_o=1. A subsequently accepted SEQ emerges alone.
- With ALU_ISSUE_PERF_EN, 3 emits and 2 stall cycles → issue_cnt_o=3, stall_cnt_o=2. Both read 0 after rst_i.
